dir_cmd_queue: RTL and testbench

Direction-command front end that sits directly upstream of the direction FSM and the snake movement stage. It merges the OR'd board-button, PS/2 and online direction requests into single-cycle edge events. It filters out illegal turns (same direction or 180° reversal) and buffers up to DEPTH legal turns. It releases one turn per snake movement tick, so fast key sequences such as up-then-left inside one move period are not lost or collapsed into a reversal.

---
 rtl/dir_cmd_queue.sv | 124 ++++++++++++
 tb/tb_dir_cmd_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dir_cmd_queue.sv
// ============================================================================
// Module   : dir_cmd_queue
// Purpose  : Edge-detects direction requests, drops illegal turns and queues
//            legal ones, releasing one turn per movement tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_cmd_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       up_req,
    input  logic                       down_req,
    input  logic                       left_req,
    input  logic                       right_req,
    input  logic                       move_tick,
    output logic [1:0]                 dir_out,
    output logic                       dir_changed,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    req_q;
    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [1:0]    dir_q;
    logic          chg_q, ovf_q;

    logic [PW-1:0] wptr_d, rptr_d;
    logic [CW-1:0] count_d;
    logic [1:0]    dir_d;
    logic          chg_d, ovf_d;

    logic [3:0]    w_rise;
    logic          w_cand_vld;
    logic [1:0]    w_cand;
    logic [1:0]    w_ref;
    logic [1:0]    w_head;
    logic          w_legal, w_push, w_pop, w_full;

    // Request bits ordered {up, down, left, right} matching priority.
    assign w_rise = {up_req, down_req, left_req, right_req} & ~req_q;

    always_comb begin
        w_cand_vld = 1'b1;
        w_cand     = 2'd0;
        if (w_rise[3])      w_cand = 2'd0;
        else if (w_rise[2]) w_cand = 2'd1;
        else if (w_rise[1]) w_cand = 2'd2;
        else if (w_rise[0]) w_cand = 2'd3;
        else                w_cand_vld = 1'b0;
    end

    assign w_ref  = (count_q != '0) ? mem_q[wptr_q - PW'(1)] : dir_q;
    assign w_head = mem_q[rptr_q];
    assign w_full = (count_q == CW'(DEPTH));
    assign w_pop  = move_tick && (count_q != '0);
    // Flipping bit 0 maps each direction onto its opposite (up<->down, left<->right).
    assign w_legal = w_cand_vld && (w_cand != w_ref) && (w_cand != (w_ref ^ 2'b01));
    assign w_push  = w_legal && (!w_full || w_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dir_d   = dir_q;
        chg_d   = 1'b0;
        ovf_d   = 1'b0;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            dir_d   = INIT_DIR;
        end else begin
            if (w_push) wptr_d = wptr_q + PW'(1);
            if (w_pop) begin
                rptr_d = rptr_q + PW'(1);
                dir_d  = w_head;
                chg_d  = (w_head != dir_q);
            end
            if (w_push && !w_pop)      count_d = count_q + CW'(1);
            else if (!w_push && w_pop) count_d = count_q - CW'(1);
            ovf_d = w_legal && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dir_q   <= INIT_DIR;
            chg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
        end else begin
            req_q   <= {up_req, down_req, left_req, right_req};
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            chg_q   <= chg_d;
            ovf_q   <= ovf_d;
            if (w_push && !clear) mem_q[wptr_q] <= w_cand;
        end
    end

    assign dir_out     = dir_q;
    assign dir_changed = chg_q;
    assign count       = count_q;
    assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_dir_cmd_queue.sv
// ============================================================================
// Module   : tb_dir_cmd_queue
// Purpose  : Directed stimulus with a scoreboard of expected dir_out updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dir_cmd_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       up_req = 1'b0, down_req = 1'b0, left_req = 1'b0, right_req = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] dir_out;
    logic       dir_changed;
    logic [2:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int chg_seen = 0;
    int chg_exp = 0;
    logic [1:0] exp_q [$];

    dir_cmd_queue #(.DEPTH(4), .INIT_DIR(2'd3)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .up_req(up_req), .down_req(down_req), .left_req(left_req), .right_req(right_req),
        .move_tick(move_tick), .dir_out(dir_out), .dir_changed(dir_changed),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle stimulus {up,down,left,right,move_tick} followed by an idle cycle
    // so the request delay registers return low before the next pulse.
    task automatic pulse(input logic [4:0] v, input string name,
                         input int exp_cnt, input logic exp_ovf);
        {up_req, down_req, left_req, right_req, move_tick} = v;
        tick();
        chk({name, "_count"}, count, exp_cnt);
        chk({name, "_ovf"}, overflow, exp_ovf);
        {up_req, down_req, left_req, right_req, move_tick} = 5'b0;
        tick();
        chk({name, "_ovf_clr"}, overflow, 0);
    endtask

    task automatic expect_dir(input logic [1:0] d);
        exp_q.push_back(d);
        chg_exp++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_dir", dir_out, 3);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (dir_changed === 1'b1) begin
                chg_seen++;
                if (exp_q.size() == 0) chk("unexpected_dir_changed", 1, 0);
                else chk("sb_dir_out", dir_out, exp_q.pop_front());
            end
        end
    endtask

    localparam logic [4:0] UP = 5'b10000, DN = 5'b01000, LT = 5'b00100,
                           RT = 5'b00010, MT = 5'b00001;

    initial begin
        fork
            monitor();
        join_none

        // Reset values while rst is held
        #12;
        chk("rst_count", count, 0);
        chk("rst_dir", dir_out, 3);
        chk("rst_chg", dir_changed, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // 1: single command round trip
        pulse(UP, "t1_up", 1, 0);
        expect_dir(2'd0);
        pulse(MT, "t1_mt", 0, 0);
        chk("t1_dir", dir_out, 0);
        chk("t1_chg_once", dir_changed, 0);

        // Empty-queue tick leaves dir_out alone
        pulse(MT, "empty_mt", 0, 0);
        chk("empty_mt_dir", dir_out, 0);

        // 2: reverse and same-direction rejection
        do_clear();
        pulse(LT, "t2_rev", 0, 0);
        pulse(RT, "t2_same", 0, 0);

        // 3: filtering against the queued tail
        pulse(UP, "t3_up", 1, 0);
        pulse(DN, "t3_down", 1, 0);
        pulse(LT, "t3_left", 2, 0);
        expect_dir(2'd0);
        pulse(MT, "t3_mt1", 1, 0);
        chk("t3_dir1", dir_out, 0);
        expect_dir(2'd2);
        pulse(MT, "t3_mt2", 0, 0);
        chk("t3_dir2", dir_out, 2);

        // 4: full queue overflow, then push+pop on a full queue
        do_clear();
        pulse(UP, "t4_f1", 1, 0);
        pulse(LT, "t4_f2", 2, 0);
        pulse(UP, "t4_f3", 3, 0);
        pulse(LT, "t4_f4", 4, 0);
        pulse(DN, "t4_drop", 4, 1);
        expect_dir(2'd0);
        pulse(DN | MT, "t4_swap", 4, 0);
        chk("t4_swap_dir", dir_out, 0);
        expect_dir(2'd2); pulse(MT, "t4_d1", 3, 0);
        expect_dir(2'd0); pulse(MT, "t4_d2", 2, 0);
        expect_dir(2'd2); pulse(MT, "t4_d3", 1, 0);
        expect_dir(2'd1); pulse(MT, "t4_d4", 0, 0);
        chk("t4_final_dir", dir_out, 1);

        // 5: simultaneous rises and held keys
        do_clear();
        {up_req, left_req} = 2'b11;
        tick();
        chk("t5_prio_count", count, 1);
        repeat (10) tick();
        chk("t5_hold_count", count, 1);
        {up_req, left_req} = 2'b00;
        tick();
        expect_dir(2'd0);
        pulse(MT, "t5_mt", 0, 0);
        chk("t5_dir", dir_out, 0);

        // Down outranks left when both rise together
        do_clear();
        pulse(DN | LT, "t5b_prio", 1, 0);
        expect_dir(2'd1);
        pulse(MT, "t5b_mt", 0, 0);
        chk("t5b_dir", dir_out, 1);

        // 6: clear with entries pending, then asynchronous reset
        do_clear();
        pulse(UP, "t6_a", 1, 0);
        pulse(LT, "t6_b", 2, 0);
        pulse(UP, "t6_c", 3, 0);
        do_clear();
        tick();
        chk("t6_clear_hold", count, 0);
        pulse(UP, "t6_d", 1, 0);
        expect_dir(2'd0);
        pulse(LT | MT, "t6_e", 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_dir", dir_out, 3);
        rst = 1'b0;
        tick();
        tick();

        chk("sb_drained", exp_q.size(), 0);
        chk("sb_pulse_count", chg_seen, chg_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
